// File: rtl/hamming_fitness_evaluator_if.sv
// Request/response bundle between the GA core (master) and a fitness responder (slave).
interface hamming_fitness_evaluator_if #(
  parameter int IndividualWidth = 32,
  parameter int ErrorWidth      = 32
);
  logic                       fitnessStart;
  logic [IndividualWidth-1:0] fitnessIndividual;
  logic                       fitnessFinish;
  logic [ErrorWidth-1:0]      fitnessError;

  modport master (
    output fitnessStart,
    output fitnessIndividual,
    input  fitnessFinish,
    input  fitnessError
  );

  modport slave (
    input  fitnessStart,
    input  fitnessIndividual,
    output fitnessFinish,
    output fitnessError
  );
endinterface

// File: rtl/hamming_fitness_evaluator.sv
// Serial Hamming-distance fitness responder: error = popcount(individual ^ Target), BitsPerCycle per clock.
// Optional result cache for repeated individuals is enabled by defining FITNESS_CACHE_EN.
module hamming_fitness_evaluator #(
  parameter int                         IndividualWidth = 32,
  parameter int                         ErrorWidth      = 32,
  parameter int                         BitsPerCycle    = 4,
  parameter logic [IndividualWidth-1:0] Target          = {16{2'b10}}
) (
  input  logic                      clk,
  input  logic                      rst,
  hamming_fitness_evaluator_if.slave fit
);
  localparam int Chunks   = IndividualWidth / BitsPerCycle;
  localparam int AccWidth = $clog2(IndividualWidth + 1);
  localparam int CntWidth = (Chunks > 1) ? $clog2(Chunks) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [AccWidth-1:0] popCount(input logic [BitsPerCycle-1:0] v);
    logic [AccWidth-1:0] n;
    n = {AccWidth{1'b0}};
    for (int i = 0; i < BitsPerCycle; i++) begin
      n = n + AccWidth'(v[i]);
    end
    return n;
  endfunction

  state_t                     state_r;
  state_t                     stateNext_s;
  logic                       startPrev_r;
  logic                       startRise_s;
  logic [IndividualWidth-1:0] diff_r;
  logic [AccWidth-1:0]        acc_r;
  logic [CntWidth-1:0]        cnt_r;
  logic                       lastChunk_s;
  logic                       cacheHit_s;
  logic [AccWidth-1:0]        cacheErrorSel_s;

  assign startRise_s = fit.fitnessStart & ~startPrev_r;
  assign lastChunk_s = (cnt_r == CntWidth'(Chunks - 1));

`ifdef FITNESS_CACHE_EN
  logic                       cacheValid_r;
  logic [IndividualWidth-1:0] cacheIndividual_r;
  logic [AccWidth-1:0]        cacheError_r;
  logic [IndividualWidth-1:0] pendIndividual_r;

  assign cacheHit_s      = cacheValid_r && (fit.fitnessIndividual == cacheIndividual_r);
  assign cacheErrorSel_s = cacheError_r;

  // Cache bookkeeping; a hit rewrites the same entry, which is harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      cacheValid_r      <= 1'b0;
      cacheIndividual_r <= {IndividualWidth{1'b0}};
      cacheError_r      <= {AccWidth{1'b0}};
      pendIndividual_r  <= {IndividualWidth{1'b0}};
    end else begin
      if (state_r == IDLE && startRise_s) begin
        pendIndividual_r <= fit.fitnessIndividual;
      end
      if (state_r == DONE) begin
        cacheValid_r      <= 1'b1;
        cacheIndividual_r <= pendIndividual_r;
        cacheError_r      <= acc_r;
      end
    end
  end
`else
  assign cacheHit_s      = 1'b0;
  assign cacheErrorSel_s = {AccWidth{1'b0}};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Next-state decode; requests outside IDLE are dropped.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      IDLE: begin
        if (startRise_s) begin
          if (cacheHit_s) begin
            stateNext_s = DONE;
          end else begin
            stateNext_s = BUSY;
          end
        end else begin
          stateNext_s = IDLE;
        end
      end
      BUSY: begin
        if (lastChunk_s) begin
          stateNext_s = DONE;
        end else begin
          stateNext_s = BUSY;
        end
      end
      DONE:    stateNext_s = IDLE;
      default: stateNext_s = IDLE;
    endcase
  end

  // Datapath and registered result; a cache hit preloads the accumulator with the stored error.
  always_ff @(posedge clk) begin
    if (rst) begin
      startPrev_r       <= 1'b0;
      diff_r            <= {IndividualWidth{1'b0}};
      acc_r             <= {AccWidth{1'b0}};
      cnt_r             <= {CntWidth{1'b0}};
      fit.fitnessFinish <= 1'b0;
      fit.fitnessError  <= {ErrorWidth{1'b0}};
    end else begin
      startPrev_r       <= fit.fitnessStart;
      fit.fitnessFinish <= 1'b0;
      case (state_r)
        IDLE: begin
          if (startRise_s) begin
            diff_r <= fit.fitnessIndividual ^ Target;
            acc_r  <= cacheHit_s ? cacheErrorSel_s : {AccWidth{1'b0}};
            cnt_r  <= {CntWidth{1'b0}};
          end
        end
        BUSY: begin
          acc_r  <= acc_r + popCount(diff_r[BitsPerCycle-1:0]);
          diff_r <= diff_r >> BitsPerCycle;
          cnt_r  <= cnt_r + CntWidth'(1);
        end
        DONE: begin
          fit.fitnessFinish <= 1'b1;
          fit.fitnessError  <= ErrorWidth'(acc_r);
        end
        default: begin
          fit.fitnessFinish <= 1'b0;
        end
      endcase
    end
  end
endmodule
